sub_top_conv: RTL and testbench

Convolution sub-top for the fused-block CNN accelerator: one IFM BRAM (58×58×16 int8, HWC), sixteen weight BRAMs (one per PE), a 3×3 window address generator, and 16 parallel 4-lane MAC processing elements. It computes one 56×56 output pixel for 16 output channels every 36 cycles, with 2 filter sets covering 32 output channels. Compute beats are framed externally by per-PE `PE_reset`/`PE_finish` pulses.

---
 rtl/sub_top_conv_pkg.sv | 48 ++++
 rtl/conv_mac_pe.sv | 56 +++++
 rtl/sub_top_conv.sv | 235 +++++++++++++++++++++++
 tb/tb_sub_top_conv.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_top_conv_pkg.sv
// Shared constants, generator types and the activation/saturation helper for sub_top_conv.
// Optional feature macro: SUB_TOP_CONV_RELU_EN (ReLU + unsigned saturation when defined).
package sub_top_conv_pkg;

  localparam int unsigned IFM_W          = 58;
  localparam int unsigned OFM_W          = 56;
  localparam int unsigned C_IN           = 16;
  localparam int unsigned K              = 3;
  localparam int unsigned NUM_PE         = 16;
  localparam int unsigned WORDS_PER_BEAT = 4;
  localparam int unsigned BEATS          = 36;
  localparam int unsigned FILTER_SETS    = 2;
  localparam int unsigned IFM_DEPTH      = 13456;
  localparam int unsigned W_DEPTH        = 72;

  localparam int unsigned IFM_AW = $clog2(IFM_DEPTH);
  localparam int unsigned W_AW   = $clog2(W_DEPTH);

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_RUN  = 2'd1,
    GEN_DONE = 2'd2
  } gen_state_e;

  // Window generator position, slowest field first
  typedef struct packed {
    logic       f;
    logic [5:0] oy;
    logic [5:0] ox;
    logic [1:0] kh;
    logic [1:0] kw;
    logic [1:0] cw;
  } gen_cnt_t;

  // Activation followed by saturation to an 8-bit result
  function automatic logic [7:0] act_sat(input logic signed [31:0] x);
`ifdef SUB_TOP_CONV_RELU_EN
    if (x < 32'sd0)        return 8'h00;
    else if (x > 32'sd255) return 8'hFF;
    else                   return x[7:0];
`else
    if (x < -32'sd128)     return 8'h80;
    else if (x > 32'sd127) return 8'h7F;
    else                   return x[7:0];
`endif
  endfunction

endpackage

// File: rtl/conv_mac_pe.sv
// 4-lane signed int8 MAC with 32-bit wrapping accumulator and activation output stage.
// Output activation depends on SUB_TOP_CONV_RELU_EN (see sub_top_conv_pkg::act_sat).
module conv_mac_pe
  import sub_top_conv_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ifm_word,
  input  logic [31:0] w_word,
  input  logic        pe_reset,
  input  logic        pe_finish,
  output logic        valid,
  output logic [7:0]  ofm_active
);

  logic signed [7:0]  ia_c   [WORDS_PER_BEAT];
  logic signed [7:0]  wa_c   [WORDS_PER_BEAT];
  logic signed [15:0] prod_c [WORDS_PER_BEAT];
  logic signed [31:0] p_c;
  logic signed [31:0] sum_c;
  logic signed [31:0] shifted_c;
  logic signed [31:0] acc;

  // Beat dot product; lane 0 sits in the top byte
  always_comb begin
    p_c = 32'sd0;
    for (int i = 0; i < int'(WORDS_PER_BEAT); i++) begin
      ia_c[i]   = ifm_word[31-8*i -: 8];
      wa_c[i]   = w_word[31-8*i -: 8];
      prod_c[i] = 16'(ia_c[i]) * 16'(wa_c[i]);
      p_c       = p_c + 32'(prod_c[i]);
    end
  end

  // First beat restarts the sum; finish uses the sum including this beat
  always_comb begin
    sum_c     = (pe_reset ? 32'sd0 : acc) + p_c;
    shifted_c = sum_c >>> OUT_SHIFT;
  end

  // Accumulator, result register and one-cycle valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 32'sd0;
      valid      <= 1'b0;
      ofm_active <= 8'h00;
    end else begin
      acc   <= sum_c;
      valid <= pe_finish;
      if (pe_finish) ofm_active <= act_sat(shifted_c);
    end
  end

endmodule

// File: rtl/sub_top_conv.sv
// Convolution sub-top: IFM/weight BRAMs, 3x3 window address generator and 16 MAC PEs.
// Optional feature macro: SUB_TOP_CONV_RELU_EN (ReLU + unsigned saturation when defined).
module sub_top_conv
  import sub_top_conv_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_rd_en_IFM,
  input  logic        wr_rd_en_Weight,
  input  logic [31:0] addr,
  input  logic [31:0] data_in_IFM,
  input  logic [31:0] data_in_Weight_0,
  input  logic [31:0] data_in_Weight_1,
  input  logic [31:0] data_in_Weight_2,
  input  logic [31:0] data_in_Weight_3,
  input  logic [31:0] data_in_Weight_4,
  input  logic [31:0] data_in_Weight_5,
  input  logic [31:0] data_in_Weight_6,
  input  logic [31:0] data_in_Weight_7,
  input  logic [31:0] data_in_Weight_8,
  input  logic [31:0] data_in_Weight_9,
  input  logic [31:0] data_in_Weight_10,
  input  logic [31:0] data_in_Weight_11,
  input  logic [31:0] data_in_Weight_12,
  input  logic [31:0] data_in_Weight_13,
  input  logic [31:0] data_in_Weight_14,
  input  logic [31:0] data_in_Weight_15,
  input  logic        cal_start,
  input  logic [15:0] PE_reset,
  input  logic [15:0] PE_finish,
  output logic [15:0] valid,
  output logic [7:0]  OFM_active_0,
  output logic [7:0]  OFM_active_1,
  output logic [7:0]  OFM_active_2,
  output logic [7:0]  OFM_active_3,
  output logic [7:0]  OFM_active_4,
  output logic [7:0]  OFM_active_5,
  output logic [7:0]  OFM_active_6,
  output logic [7:0]  OFM_active_7,
  output logic [7:0]  OFM_active_8,
  output logic [7:0]  OFM_active_9,
  output logic [7:0]  OFM_active_10,
  output logic [7:0]  OFM_active_11,
  output logic [7:0]  OFM_active_12,
  output logic [7:0]  OFM_active_13,
  output logic [7:0]  OFM_active_14,
  output logic [7:0]  OFM_active_15,
  output logic [31:0] OFM
);

  gen_state_e        state, state_n;
  gen_cnt_t          cnt, cnt_n;
  logic              adv_c, clr_c, last_c;
  logic [IFM_AW-1:0] row_c, col_c, ifm_addr_c, ifm_addr_r;
  logic [W_AW-1:0]   w_addr_c, w_addr_r;
  logic              ifm_we_c, w_we_c;
  logic [31:0]       ifm_mem [IFM_DEPTH];
  logic [31:0]       ifm_q;
  logic [31:0]       w_din   [NUM_PE];
  logic [7:0]        ofm_act [NUM_PE];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[31:IFM_AW];

  assign w_din[0]  = data_in_Weight_0;
  assign w_din[1]  = data_in_Weight_1;
  assign w_din[2]  = data_in_Weight_2;
  assign w_din[3]  = data_in_Weight_3;
  assign w_din[4]  = data_in_Weight_4;
  assign w_din[5]  = data_in_Weight_5;
  assign w_din[6]  = data_in_Weight_6;
  assign w_din[7]  = data_in_Weight_7;
  assign w_din[8]  = data_in_Weight_8;
  assign w_din[9]  = data_in_Weight_9;
  assign w_din[10] = data_in_Weight_10;
  assign w_din[11] = data_in_Weight_11;
  assign w_din[12] = data_in_Weight_12;
  assign w_din[13] = data_in_Weight_13;
  assign w_din[14] = data_in_Weight_14;
  assign w_din[15] = data_in_Weight_15;

  // Last beat of the whole run: f=1, oy=ox=55, end of window
  assign last_c = (cnt.f  == 1'(FILTER_SETS - 1))    &&
                  (cnt.oy == 6'(OFM_W - 1))          &&
                  (cnt.ox == 6'(OFM_W - 1))          &&
                  (cnt.kh == 2'(K - 1))              &&
                  (cnt.kw == 2'(K - 1))              &&
                  (cnt.cw == 2'(WORDS_PER_BEAT - 1));

  // Generator state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= GEN_IDLE;
    else        state <= state_n;
  end

  // Generator next state: cal_start low always returns to idle
  always_comb begin
    state_n = state;
    if (!cal_start) begin
      state_n = GEN_IDLE;
    end else begin
      case (state)
        GEN_IDLE: state_n = GEN_RUN;
        GEN_RUN:  if (last_c) state_n = GEN_DONE;
        GEN_DONE: state_n = GEN_DONE;
        default:  state_n = GEN_IDLE;
      endcase
    end
  end

  // Generator controls: advance while running, clear while cal_start is low
  always_comb begin
    adv_c = 1'b0;
    clr_c = 1'b0;
    if (!cal_start)              clr_c = 1'b1;
    else if (state != GEN_DONE)  adv_c = 1'b1;
  end

  // Nested counter increment, cw fastest; holds on the final beat
  always_comb begin
    cnt_n = cnt;
    if (clr_c) begin
      cnt_n = '0;
    end else if (adv_c && !last_c) begin
      if (cnt.cw != 2'(WORDS_PER_BEAT - 1)) begin
        cnt_n.cw = cnt.cw + 2'd1;
      end else begin
        cnt_n.cw = 2'd0;
        if (cnt.kw != 2'(K - 1)) begin
          cnt_n.kw = cnt.kw + 2'd1;
        end else begin
          cnt_n.kw = 2'd0;
          if (cnt.kh != 2'(K - 1)) begin
            cnt_n.kh = cnt.kh + 2'd1;
          end else begin
            cnt_n.kh = 2'd0;
            if (cnt.ox != 6'(OFM_W - 1)) begin
              cnt_n.ox = cnt.ox + 6'd1;
            end else begin
              cnt_n.ox = 6'd0;
              if (cnt.oy != 6'(OFM_W - 1)) begin
                cnt_n.oy = cnt.oy + 6'd1;
              end else begin
                cnt_n.oy = 6'd0;
                cnt_n.f  = cnt.f + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Window addresses for the current beat
  always_comb begin
    row_c      = IFM_AW'(cnt.oy) + IFM_AW'(cnt.kh);
    col_c      = IFM_AW'(cnt.ox) + IFM_AW'(cnt.kw);
    ifm_addr_c = (row_c * IFM_AW'(IFM_W) + col_c) * IFM_AW'(WORDS_PER_BEAT) + IFM_AW'(cnt.cw);
    w_addr_c   = W_AW'(cnt.f) * W_AW'(BEATS) +
                 (W_AW'(cnt.kh) * W_AW'(K) + W_AW'(cnt.kw)) * W_AW'(WORDS_PER_BEAT) +
                 W_AW'(cnt.cw);
  end

  // Counters, address registers and IFM read register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      ifm_addr_r <= '0;
      w_addr_r   <= '0;
      ifm_q      <= 32'h0;
    end else begin
      cnt        <= cnt_n;
      ifm_addr_r <= ifm_addr_c;
      w_addr_r   <= w_addr_c;
      ifm_q      <= ifm_mem[ifm_addr_r];
    end
  end

  // Loads are only accepted while the generator is stopped
  assign ifm_we_c = wr_rd_en_IFM && !cal_start && (addr[IFM_AW-1:0] < IFM_AW'(IFM_DEPTH));
  assign w_we_c   = wr_rd_en_Weight && !cal_start && (addr[W_AW-1:0] < W_AW'(W_DEPTH));

  // IFM BRAM write port
  always_ff @(posedge clk) begin
    if (ifm_we_c) ifm_mem[addr[IFM_AW-1:0]] <= data_in_IFM;
  end

  for (genvar k = 0; k < int'(NUM_PE); k++) begin : g_pe
    logic [31:0] w_mem [W_DEPTH];
    logic [31:0] w_q;

    // Weight BRAM write port for this PE
    always_ff @(posedge clk) begin
      if (w_we_c) w_mem[addr[W_AW-1:0]] <= w_din[k];
    end

    // Weight read register for this PE
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) w_q <= 32'h0;
      else        w_q <= w_mem[w_addr_r];
    end

    conv_mac_pe #(.OUT_SHIFT(OUT_SHIFT)) u_pe (
      .clk        (clk),
      .rst_n      (reset),
      .ifm_word   (ifm_q),
      .w_word     (w_q),
      .pe_reset   (PE_reset[k]),
      .pe_finish  (PE_finish[k]),
      .valid      (valid[k]),
      .ofm_active (ofm_act[k])
    );
  end

  assign OFM_active_0  = ofm_act[0];
  assign OFM_active_1  = ofm_act[1];
  assign OFM_active_2  = ofm_act[2];
  assign OFM_active_3  = ofm_act[3];
  assign OFM_active_4  = ofm_act[4];
  assign OFM_active_5  = ofm_act[5];
  assign OFM_active_6  = ofm_act[6];
  assign OFM_active_7  = ofm_act[7];
  assign OFM_active_8  = ofm_act[8];
  assign OFM_active_9  = ofm_act[9];
  assign OFM_active_10 = ofm_act[10];
  assign OFM_active_11 = ofm_act[11];
  assign OFM_active_12 = ofm_act[12];
  assign OFM_active_13 = ofm_act[13];
  assign OFM_active_14 = ofm_act[14];
  assign OFM_active_15 = ofm_act[15];
  assign OFM = {ofm_act[0], ofm_act[1], ofm_act[2], ofm_act[3]};

endmodule

// File: tb/tb_sub_top_conv.sv
// Self-checking bench for sub_top_conv (OUT_SHIFT=0 and OUT_SHIFT=4 instances on shared stimulus).
// Expected activation follows SUB_TOP_CONV_RELU_EN when defined.
module tb_sub_top_conv;

  localparam int LOAD_N = 1400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_rd_en_IFM = 1'b0;
  logic        wr_rd_en_Weight = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_in_IFM = 32'h0;
  logic [31:0] data_in_w [16];
  logic        cal_start = 1'b0;
  logic [15:0] PE_reset = 16'h0;
  logic [15:0] PE_finish = 16'h0;
  logic [15:0] valid_a, valid_b;
  logic [7:0]  ofm_a [16];
  logic [7:0]  ofm_b [16];
  logic [31:0] OFM_a, OFM_b;

  always #5 clk = ~clk;

  sub_top_conv #(.OUT_SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .wr_rd_en_IFM(wr_rd_en_IFM), .wr_rd_en_Weight(wr_rd_en_Weight),
    .addr(addr), .data_in_IFM(data_in_IFM),
    .data_in_Weight_0(data_in_w[0]),   .data_in_Weight_1(data_in_w[1]),
    .data_in_Weight_2(data_in_w[2]),   .data_in_Weight_3(data_in_w[3]),
    .data_in_Weight_4(data_in_w[4]),   .data_in_Weight_5(data_in_w[5]),
    .data_in_Weight_6(data_in_w[6]),   .data_in_Weight_7(data_in_w[7]),
    .data_in_Weight_8(data_in_w[8]),   .data_in_Weight_9(data_in_w[9]),
    .data_in_Weight_10(data_in_w[10]), .data_in_Weight_11(data_in_w[11]),
    .data_in_Weight_12(data_in_w[12]), .data_in_Weight_13(data_in_w[13]),
    .data_in_Weight_14(data_in_w[14]), .data_in_Weight_15(data_in_w[15]),
    .cal_start(cal_start), .PE_reset(PE_reset), .PE_finish(PE_finish), .valid(valid_a),
    .OFM_active_0(ofm_a[0]),   .OFM_active_1(ofm_a[1]),   .OFM_active_2(ofm_a[2]),
    .OFM_active_3(ofm_a[3]),   .OFM_active_4(ofm_a[4]),   .OFM_active_5(ofm_a[5]),
    .OFM_active_6(ofm_a[6]),   .OFM_active_7(ofm_a[7]),   .OFM_active_8(ofm_a[8]),
    .OFM_active_9(ofm_a[9]),   .OFM_active_10(ofm_a[10]), .OFM_active_11(ofm_a[11]),
    .OFM_active_12(ofm_a[12]), .OFM_active_13(ofm_a[13]), .OFM_active_14(ofm_a[14]),
    .OFM_active_15(ofm_a[15]), .OFM(OFM_a)
  );

  sub_top_conv #(.OUT_SHIFT(4)) dut_b (
    .clk(clk), .reset(reset), .wr_rd_en_IFM(wr_rd_en_IFM), .wr_rd_en_Weight(wr_rd_en_Weight),
    .addr(addr), .data_in_IFM(data_in_IFM),
    .data_in_Weight_0(data_in_w[0]),   .data_in_Weight_1(data_in_w[1]),
    .data_in_Weight_2(data_in_w[2]),   .data_in_Weight_3(data_in_w[3]),
    .data_in_Weight_4(data_in_w[4]),   .data_in_Weight_5(data_in_w[5]),
    .data_in_Weight_6(data_in_w[6]),   .data_in_Weight_7(data_in_w[7]),
    .data_in_Weight_8(data_in_w[8]),   .data_in_Weight_9(data_in_w[9]),
    .data_in_Weight_10(data_in_w[10]), .data_in_Weight_11(data_in_w[11]),
    .data_in_Weight_12(data_in_w[12]), .data_in_Weight_13(data_in_w[13]),
    .data_in_Weight_14(data_in_w[14]), .data_in_Weight_15(data_in_w[15]),
    .cal_start(cal_start), .PE_reset(PE_reset), .PE_finish(PE_finish), .valid(valid_b),
    .OFM_active_0(ofm_b[0]),   .OFM_active_1(ofm_b[1]),   .OFM_active_2(ofm_b[2]),
    .OFM_active_3(ofm_b[3]),   .OFM_active_4(ofm_b[4]),   .OFM_active_5(ofm_b[5]),
    .OFM_active_6(ofm_b[6]),   .OFM_active_7(ofm_b[7]),   .OFM_active_8(ofm_b[8]),
    .OFM_active_9(ofm_b[9]),   .OFM_active_10(ofm_b[10]), .OFM_active_11(ofm_b[11]),
    .OFM_active_12(ofm_b[12]), .OFM_active_13(ofm_b[13]), .OFM_active_14(ofm_b[14]),
    .OFM_active_15(ofm_b[15]), .OFM(OFM_b)
  );

  typedef struct packed {
    logic [15:0]      mask;
    logic [15:0][7:0] a;
    logic [15:0][7:0] b;
  } exp_t;

  typedef struct {
    logic [7:0] ifm_b;
    logic [7:0] w_b;
    bit         by_k;
    int         frames;
    bit         pulse;
    int         sum;
  } vec_t;

  exp_t             sb [$];
  logic [15:0][7:0] cur_a, cur_b;
  int               sums [16];
  bit [31:0]        ifm_m [13456];
  bit [31:0]        w_m [16][72];
  int               n_chk = 0;
  int               n_err = 0;

  function automatic logic [7:0] act(int s);
`ifdef SUB_TOP_CONV_RELU_EN
    if (s < 0)   return 8'h00;
    if (s > 255) return 8'hFF;
    return 8'(s);
`else
    if (s < -128) return 8'h80;
    if (s > 127)  return 8'h7F;
    return 8'(s);
`endif
  endfunction

  function automatic int dot4(bit [31:0] a, bit [31:0] b);
    int s;
    byte signed x, y;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = byte'(a >> (8 * i));
      y = byte'(b >> (8 * i));
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  // Reference pixel j for PE k from the window formulas
  function automatic int model_sum(int k, int j);
    int f, oy, ox, s, ia, wa;
    f  = j / 3136;
    oy = (j % 3136) / 56;
    ox = j % 56;
    s  = 0;
    for (int kh = 0; kh < 3; kh++)
      for (int kw = 0; kw < 3; kw++)
        for (int cw = 0; cw < 4; cw++) begin
          ia = ((oy + kh) * 58 + ox + kw) * 4 + cw;
          wa = f * 36 + (kh * 3 + kw) * 4 + cw;
          s += dot4(ifm_m[ia], w_m[k][wa]);
        end
    return s;
  endfunction

  function automatic bit [31:0] rnd_word();
    bit [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'($urandom_range(0, 15) - 8);
    return w;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic chk_zero();
    chk("rst_valid_a", 32'(valid_a), 32'h0);
    chk("rst_valid_b", 32'(valid_b), 32'h0);
    chk("rst_OFM_a", OFM_a, 32'h0);
    chk("rst_OFM_b", OFM_b, 32'h0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rst_ofm_a%0d", k), 32'(ofm_a[k]), 32'h0);
      chk($sformatf("rst_ofm_b%0d", k), 32'(ofm_b[k]), 32'h0);
    end
  endtask

  // Record expected outputs for the PEs finishing this cycle
  task automatic push(logic [15:0] mask);
    exp_t e;
    for (int k = 0; k < 16; k++)
      if (mask[k]) begin
        cur_a[k] = act(sums[k]);
        cur_b[k] = act(sums[k] >>> 4);
      end
    e.mask = mask;
    e.a    = cur_a;
    e.b    = cur_b;
    sb.push_back(e);
  endtask

  // One clock; valid must echo the sampled finish mask, results popped from the scoreboard
  task automatic tick();
    logic [15:0] f;
    exp_t e;
    f = reset ? PE_finish : 16'h0;
    @(posedge clk);
    #1;
    chk("valid_a", 32'(valid_a), 32'(f));
    chk("valid_b", 32'(valid_b), 32'(f));
    if (f != 16'h0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_empty: got valid %0h want no result", f);
      end else begin
        e = sb.pop_front();
        chk("mask", 32'(f), 32'(e.mask));
        for (int k = 0; k < 16; k++) begin
          chk($sformatf("ofm_a%0d", k), 32'(ofm_a[k]), 32'(e.a[k]));
          chk($sformatf("ofm_b%0d", k), 32'(ofm_b[k]), 32'(e.b[k]));
        end
        chk("OFM_a", OFM_a, {e.a[0], e.a[1], e.a[2], e.a[3]});
        chk("OFM_b", OFM_b, {e.b[0], e.b[1], e.b[2], e.b[3]});
      end
    end
  endtask

  task automatic fill_ifm(bit rnd, logic [7:0] b);
    wr_rd_en_IFM = 1'b1;
    for (int i = 0; i < LOAD_N; i++) begin
      addr        = 32'(i);
      data_in_IFM = rnd ? rnd_word() : {4{b}};
      ifm_m[i]    = data_in_IFM;
      tick();
    end
    wr_rd_en_IFM = 1'b0;
  endtask

  task automatic fill_w(bit rnd, logic [7:0] b, bit by_k);
    wr_rd_en_Weight = 1'b1;
    for (int i = 0; i < 72; i++) begin
      addr = 32'(i);
      for (int k = 0; k < 16; k++) begin
        data_in_w[k] = rnd ? rnd_word() : (by_k ? {4{8'(k)}} : {4{b}});
        w_m[k][i]    = data_in_w[k];
      end
      tick();
    end
    wr_rd_en_Weight = 1'b0;
  endtask

  task automatic drive_frame(int j, bit use_model, int base, bit by_k);
    for (int t = 0; t < 36; t++) begin
      PE_reset  = (t == 0)  ? 16'hFFFF : 16'h0;
      PE_finish = (t == 35) ? 16'hFFFF : 16'h0;
      if (t == 35) begin
        for (int k = 0; k < 16; k++)
          sums[k] = use_model ? model_sum(k, j) : (by_k ? base * k : base);
        push(16'hFFFF);
      end
      tick();
    end
    PE_reset  = 16'h0;
    PE_finish = 16'h0;
  endtask

  task automatic run_frames(int n, bit use_model, int base, bit by_k, bit pulse);
    cal_start = 1'b0;
    tick();
    cal_start = 1'b1;
    if (pulse) begin
      wr_rd_en_IFM = 1'b1;
      addr         = 32'h0;
      data_in_IFM  = 32'h7F7F7F7F;
    end
    tick();
    wr_rd_en_IFM = 1'b0;
    tick();
    for (int j = 0; j < n; j++) drive_frame(j, use_model, base, by_k);
    tick();
    cal_start = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    tbl[0] = '{ifm_b: 8'h01, w_b: 8'h01, by_k: 1'b0, frames: 200, pulse: 1'b0, sum: 144};
    tbl[1] = '{ifm_b: 8'h01, w_b: 8'hFF, by_k: 1'b0, frames: 2,   pulse: 1'b0, sum: -144};
    tbl[2] = '{ifm_b: 8'h01, w_b: 8'h00, by_k: 1'b1, frames: 2,   pulse: 1'b0, sum: 144};
    tbl[3] = '{ifm_b: 8'h01, w_b: 8'h01, by_k: 1'b0, frames: 2,   pulse: 1'b1, sum: 144};

    for (int k = 0; k < 16; k++) data_in_w[k] = 32'h0;
    cur_a = '0;
    cur_b = '0;

    // Reset state
    tick();
    tick();
    chk_zero();
    reset = 1'b1;
    tick();

    // Uniform-data vectors
    for (int v = 0; v < 4; v++) begin
      fill_ifm(1'b0, tbl[v].ifm_b);
      fill_w(1'b0, tbl[v].w_b, tbl[v].by_k);
      run_frames(tbl[v].frames, 1'b0, tbl[v].sum, tbl[v].by_k, tbl[v].pulse);
    end

    // Random data, reset mid-pixel, then restart recomputes pixel (0,0)
    fill_ifm(1'b1, 8'h00);
    fill_w(1'b1, 8'h00, 1'b0);
    cal_start = 1'b1;
    tick();
    tick();
    drive_frame(0, 1'b1, 0, 1'b0);
    for (int t = 0; t < 10; t++) begin
      PE_reset = (t == 0) ? 16'hFFFF : 16'h0;
      tick();
    end
    PE_reset = 16'h0;
    reset    = 1'b0;
    #1;
    chk_zero();
    tick();
    reset = 1'b1;
    cur_a = '0;
    cur_b = '0;
    sb.delete();
    tick();
    cal_start = 1'b0;
    tick();
    run_frames(1, 1'b1, 0, 1'b0, 1'b0);

    // Single-beat pixel on PE 0: reset and finish together
    wr_rd_en_IFM = 1'b1;
    addr         = 32'h0;
    data_in_IFM  = 32'h02020202;
    ifm_m[0]     = data_in_IFM;
    tick();
    wr_rd_en_IFM    = 1'b0;
    wr_rd_en_Weight = 1'b1;
    for (int k = 0; k < 16; k++) begin
      data_in_w[k] = 32'h03030303;
      w_m[k][0]    = data_in_w[k];
    end
    tick();
    wr_rd_en_Weight = 1'b0;
    cal_start = 1'b1;
    tick();
    tick();
    PE_reset  = 16'h0001;
    PE_finish = 16'h0001;
    sums[0]   = 24;
    push(16'h0001);
    tick();
    PE_reset  = 16'h0;
    PE_finish = 16'h0;
    tick();
    cal_start = 1'b0;
    tick();

    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
